// File: rtl/jtlabrun_gfx_pkg.sv
// Labyrinth Runner gfx CPU interface: register map and shared types.
// Optional build macro JTLABRUN_CFG_READBACK_EN is consumed by jtlabrun_gfx_cpuif.
package jtlabrun_gfx_pkg;

  localparam int REG_SCRXL = 0;
  localparam int REG_SCRXH = 1;
  localparam int REG_SCRY  = 2;
  localparam int REG_OBJ   = 3;
  localparam int REG_R4    = 4;
  localparam int REG_R5    = 5;
  localparam int REG_R6    = 6;
  localparam int REG_CTRL  = 7;

  localparam int IRQ_EN   = 1;
  localparam int NMI_EN   = 0;
  localparam int FLIP     = 3;
  localparam int OBJ_BANK = 3;

  typedef enum logic {
    NMI_IDLE,
    NMI_PULSE
  } nmi_st_t;

  // A12 arrives inverted on the bus
  function automatic logic [12:0] vram_idx(
    input logic [13:0] a
  );
    return {~a[12], a[11:0]};
  endfunction

endpackage

// File: rtl/jtlabrun_gfx_cpuif_if.sv
// CPU bus between the main board and the gfx chip.
// master drives the strobe/address/data, slave returns read data.
interface jtlabrun_gfx_cpuif_if;
  logic        cpu_cen;
  logic        gfx_cs;
  logic [13:0] gfx_addr;
  logic        cpu_rnw;
  logic [7:0]  cpu_dout;
  logic [7:0]  gfx_dout;

  modport master (
    output cpu_cen, gfx_cs, gfx_addr,
    output cpu_rnw, cpu_dout,
    input  gfx_dout
  );

  modport slave (
    input  cpu_cen, gfx_cs, gfx_addr,
    input  cpu_rnw, cpu_dout,
    output gfx_dout
  );
endinterface

// File: rtl/jtframe_dual_ram.sv
// Dual-port RAM: port 0 read/write, port 1 read-only, 1-clk latency.
// Both ports read old data on a same-cycle write.
module jtframe_dual_ram #(
  parameter int DW = 8,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic [DW-1:0] data0,
  input  logic [AW-1:0] addr0,
  input  logic          we0,
  output logic [DW-1:0] q0,
  input  logic [AW-1:0] addr1,
  output logic [DW-1:0] q1
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we0) mem[addr0] <= data0;
    q0 <= mem[addr0];
    q1 <= mem[addr1];
  end
endmodule

// File: rtl/jtlabrun_gfx_irq.sv
// Vblank IRQ level and NMI pulse generator.
// NMI fires on entry to every 2**NMI_DIV-th line and never retriggers mid-pulse.
module jtlabrun_gfx_irq
  import jtlabrun_gfx_pkg::*;
#(
  parameter int NMI_LEN = 16,
  parameter int NMI_DIV = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lvbl,
  input  logic [8:0] vdump,
  input  logic       irq_en,
  input  logic       nmi_en,
  output logic       irqn,
  output logic       nmin
);
  localparam int CW = $clog2(NMI_LEN + 1);

  logic          prev_lvbl;
  logic [8:0]    prev_vdump;
  logic          trig;
  nmi_st_t       st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          nmin_nx;

  assign trig = nmi_en && (vdump != prev_vdump)
             && (vdump[NMI_DIV-1:0] == '0);

  // edge trackers keep following inputs through reset
  always_ff @(posedge clk) begin
    prev_lvbl  <= lvbl;
    prev_vdump <= vdump;
    if (rst)
      irqn <= 1'b1;
    else if (prev_lvbl && !lvbl && irq_en)
      irqn <= 1'b0;
    else if ((!prev_lvbl && lvbl) || !irq_en)
      irqn <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= NMI_IDLE;
      cnt  <= '0;
      nmin <= 1'b1;
    end else begin
      st   <= st_nx;
      cnt  <= cnt_nx;
      nmin <= nmin_nx;
    end
  end

  always_comb begin
    st_nx   = st;
    cnt_nx  = cnt;
    nmin_nx = nmin;
    unique case (st)
      NMI_IDLE: if (trig) begin
        st_nx   = NMI_PULSE;
        cnt_nx  = CW'(NMI_LEN - 1);
        nmin_nx = 1'b0;
      end
      NMI_PULSE: if (cnt == '0) begin
        st_nx   = NMI_IDLE;
        nmin_nx = 1'b1;
      end else begin
        cnt_nx = cnt - CW'(1);
      end
    endcase
  end
endmodule

// File: rtl/jtlabrun_gfx_cpuif.sv
// CPU-facing side of the Labyrinth Runner gfx chip: VRAM, control regs, IRQ/NMI.
// JTLABRUN_CFG_READBACK_EN makes control registers readable (PCB: write-only).
module jtlabrun_gfx_cpuif
  import jtlabrun_gfx_pkg::*;
#(
  parameter int NMI_LEN = 16,
  parameter int NMI_DIV = 5
) (
  input  logic       clk,
  input  logic       rst,
  jtlabrun_gfx_cpuif_if.slave bus,
  output logic       gfx_irqn,
  output logic       gfx_nmin,
  input  logic [8:0] vdump,
  input  logic       lvbl,
  input  logic [12:0] vram_addr,
  output logic [7:0] vram_data,
  output logic [8:0] scrx,
  output logic [7:0] scry,
  output logic       obj_bank,
  output logic       flip
);
  logic       vram_sel, cfg_sel, wr;
  logic [2:0] idx;
  logic [7:0] regs [8];
  logic [7:0] cfg_rd, vram_q, dout_r;
  logic       rd_vram;

  assign vram_sel = bus.gfx_cs & bus.gfx_addr[13];
  assign cfg_sel  = bus.gfx_cs
                  & (bus.gfx_addr[13:12] == 2'b00)
                  & (bus.gfx_addr[11:3] == 9'd0);
  assign wr  = ~bus.cpu_rnw & bus.cpu_cen;
  assign idx = bus.gfx_addr[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (cfg_sel && wr) begin
      regs[idx] <= bus.cpu_dout;
    end
  end

`ifdef JTLABRUN_CFG_READBACK_EN
  assign cfg_rd = cfg_sel ? regs[idx] : 8'hff;
`else
  assign cfg_rd = 8'hff;
  logic unused_regs;
  assign unused_regs = ^{regs[0], regs[1], regs[2], regs[3],
                         regs[4], regs[5], regs[6], regs[7]};
`endif

  jtframe_dual_ram #(.DW(8), .AW(13)) u_vram (
    .clk   (clk),
    .data0 (bus.cpu_dout),
    .addr0 (vram_idx(bus.gfx_addr)),
    .we0   (vram_sel & wr),
    .q0    (vram_q),
    .addr1 (vram_addr),
    .q1    (vram_data)
  );

  // VRAM data is already registered in the RAM; select it with a registered flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vram <= 1'b0;
      dout_r  <= 8'hff;
    end else begin
      rd_vram <= vram_sel;
      dout_r  <= cfg_rd;
    end
  end

  assign bus.gfx_dout = rd_vram ? vram_q : dout_r;

  assign scrx     = {regs[REG_SCRXH][0], regs[REG_SCRXL]};
  assign scry     = regs[REG_SCRY];
  assign obj_bank = regs[REG_OBJ][OBJ_BANK];
  assign flip     = regs[REG_CTRL][FLIP];

  jtlabrun_gfx_irq #(
    .NMI_LEN (NMI_LEN),
    .NMI_DIV (NMI_DIV)
  ) u_irq (
    .clk    (clk),
    .rst    (rst),
    .lvbl   (lvbl),
    .vdump  (vdump),
    .irq_en (regs[REG_CTRL][IRQ_EN]),
    .nmi_en (regs[REG_CTRL][NMI_EN]),
    .irqn   (gfx_irqn),
    .nmin   (gfx_nmin)
  );
endmodule

// File: tb/tb_jtlabrun_gfx_cpuif.sv
// Scoreboard bench for jtlabrun_gfx_cpuif: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_jtlabrun_gfx_cpuif;
  logic        clk;
  logic        rst;
  logic        lvbl;
  logic [8:0]  vdump;
  logic [12:0] vram_addr;
  logic [7:0]  vram_data;
  logic [8:0]  scrx;
  logic [7:0]  scry;
  logic        obj_bank, flip;
  logic        gfx_irqn, gfx_nmin;

  jtlabrun_gfx_cpuif_if bus();

  jtlabrun_gfx_cpuif #(.NMI_LEN(16), .NMI_DIV(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .gfx_irqn  (gfx_irqn),
    .gfx_nmin  (gfx_nmin),
    .vdump     (vdump),
    .lvbl      (lvbl),
    .vram_addr (vram_addr),
    .vram_data (vram_data),
    .scrx      (scrx),
    .scry      (scry),
    .obj_bank  (obj_bank),
    .flip      (flip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {S_DOUT, S_VDATA, S_SCRX, S_SCRY,
                S_OBJ, S_FLIP, S_IRQN, S_NMIN} sig_e;
  typedef struct {
    string      name;
    sig_e       sig;
    logic [8:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

`ifdef JTLABRUN_CFG_READBACK_EN
  localparam logic [7:0] RB77 = 8'h77;
`else
  localparam logic [7:0] RB77 = 8'hff;
`endif

  function automatic logic [8:0] probe(input sig_e s);
    case (s)
      S_DOUT:  return {1'b0, bus.gfx_dout};
      S_VDATA: return {1'b0, vram_data};
      S_SCRX:  return scrx;
      S_SCRY:  return {1'b0, scry};
      S_OBJ:   return {8'd0, obj_bank};
      S_FLIP:  return {8'd0, flip};
      S_IRQN:  return {8'd0, gfx_irqn};
      default: return {8'd0, gfx_nmin};
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() != 0) begin
      exp_t       e;
      logic [8:0] act;
      e   = sb.pop_front();
      act = probe(e.sig);
      checks++;
      if (act === e.exp) passed++;
      else $display("FAIL %s: got %h want %h", e.name, act, e.exp);
    end
  end

  task automatic push(input string n, input sig_e s, input logic [8:0] v);
    sb.push_back('{n, s, v});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [13:0] a, input logic [7:0] d);
    bus.gfx_cs   = 1'b1;
    bus.gfx_addr = a;
    bus.cpu_rnw  = 1'b0;
    bus.cpu_dout = d;
    bus.cpu_cen  = 1'b1;
    cyc();
    bus.cpu_cen  = 1'b0;
    bus.gfx_cs   = 1'b0;
    bus.cpu_rnw  = 1'b1;
  endtask

  task automatic cpu_rd(input string n, input logic [13:0] a, input logic [7:0] d);
    bus.gfx_cs   = 1'b1;
    bus.gfx_addr = a;
    bus.cpu_rnw  = 1'b1;
    cyc();
    push(n, S_DOUT, {1'b0, d});
    bus.gfx_cs   = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    lvbl         = 1'b1;
    vdump        = 9'd0;
    vram_addr    = 13'd0;
    bus.cpu_cen  = 1'b0;
    bus.gfx_cs   = 1'b0;
    bus.gfx_addr = 14'd0;
    bus.cpu_rnw  = 1'b1;
    bus.cpu_dout = 8'd0;
    repeat (3) cyc();
    push("rst_irqn", S_IRQN, 9'd1);
    push("rst_nmin", S_NMIN, 9'd1);
    push("rst_dout", S_DOUT, 9'h0ff);
    push("rst_scrx", S_SCRX, 9'd0);
    push("rst_scry", S_SCRY, 9'd0);
    push("rst_flip", S_FLIP, 9'd0);
    rst = 1'b0;
    cyc();

    // VRAM write/read, both ports, collision
    cpu_wr(14'h3ABC, 8'h5A);
    vram_addr = 13'h0ABC;
    cpu_rd("vram_rd", 14'h3ABC, 8'h5A);
    push("vram_vid", S_VDATA, 9'h05A);
    cpu_wr(14'h3ABC, 8'hA5);
    push("vram_coll_old", S_VDATA, 9'h05A);
    cyc();
    push("vram_coll_new", S_VDATA, 9'h0A5);
    cpu_wr(14'h2001, 8'h11);
    cpu_rd("vram_a12", 14'h2001, 8'h11);

    // scroll and misc registers
    cpu_wr(14'h0000, 8'h34);
    cpu_wr(14'h0001, 8'h01);
    push("scrx", S_SCRX, 9'h134);
    bus.gfx_cs   = 1'b1;
    bus.gfx_addr = 14'h0000;
    bus.cpu_rnw  = 1'b0;
    bus.cpu_dout = 8'hff;
    repeat (3) cyc();
    push("scrx_no_cen", S_SCRX, 9'h134);
    bus.gfx_cs  = 1'b0;
    bus.cpu_rnw = 1'b1;
    cpu_wr(14'h0003, 8'h08);
    push("obj_bank", S_OBJ, 9'd1);
    cpu_wr(14'h0007, 8'h08);
    push("flip", S_FLIP, 9'd1);
    cpu_wr(14'h0007, 8'h00);
    push("flip_clr", S_FLIP, 9'd0);

    // IRQ
    cpu_wr(14'h0007, 8'h02);
    push("irq_idle", S_IRQN, 9'd1);
    lvbl = 1'b0;
    cyc();
    push("irq_assert", S_IRQN, 9'd0);
    cpu_wr(14'h0007, 8'h00);
    push("irq_hold", S_IRQN, 9'd0);
    cyc();
    push("irq_clr_en", S_IRQN, 9'd1);
    lvbl = 1'b1;
    cyc();
    lvbl = 1'b0;
    cyc();
    cpu_wr(14'h0007, 8'h02);
    cyc();
    push("irq_mid_vbl", S_IRQN, 9'd1);
    lvbl = 1'b1;
    cyc();
    push("irq_vbl_end", S_IRQN, 9'd1);
    lvbl = 1'b0;
    cyc();
    push("irq_next_vbl", S_IRQN, 9'd0);
    lvbl = 1'b1;
    cyc();
    push("irq_release", S_IRQN, 9'd1);

    // NMI pulse length, no retrigger, no truncation
    vdump = 9'd31;
    cyc();
    cpu_wr(14'h0007, 8'h01);
    vdump = 9'd32;
    cyc();
    push("nmi_low0", S_NMIN, 9'd0);
    for (int i = 1; i < 16; i++) begin
      if (i == 5) vdump = 9'd64;
      if (i == 8) begin
        bus.gfx_cs   = 1'b1;
        bus.gfx_addr = 14'h0007;
        bus.cpu_rnw  = 1'b0;
        bus.cpu_dout = 8'h00;
        bus.cpu_cen  = 1'b1;
      end
      if (i == 9) begin
        bus.cpu_cen = 1'b0;
        bus.gfx_cs  = 1'b0;
        bus.cpu_rnw = 1'b1;
      end
      cyc();
      push($sformatf("nmi_low%0d", i), S_NMIN, 9'd0);
    end
    cyc();
    push("nmi_end", S_NMIN, 9'd1);
    vdump = 9'd96;
    cyc();
    push("nmi_dis", S_NMIN, 9'd1);
    cpu_wr(14'h0007, 8'h01);
    vdump = 9'd97;
    cyc();
    push("nmi_not_div", S_NMIN, 9'd1);

    // config reads and unmapped addresses
    cpu_rd("rd_unmapped", 14'h0010, 8'hff);
    cpu_wr(14'h0002, 8'h77);
    push("scry", S_SCRY, 9'h077);
    cpu_rd("rd_reg2", 14'h0002, RB77);
    cpu_rd("rd_a12_hole", 14'h1000, 8'hff);

    // reset mid-pulse and in vblank
    cpu_wr(14'h0007, 8'h03);
    lvbl = 1'b0;
    cyc();
    push("pre_rst_irqn", S_IRQN, 9'd0);
    vdump = 9'd128;
    cyc();
    push("pre_rst_nmin", S_NMIN, 9'd0);
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    push("rst2_nmin", S_NMIN, 9'd1);
    push("rst2_irqn", S_IRQN, 9'd1);
    push("rst2_scrx", S_SCRX, 9'd0);
    push("rst2_scry", S_SCRY, 9'd0);
    push("rst2_obj", S_OBJ, 9'd0);
    push("rst2_dout", S_DOUT, 9'h0ff);
    rst = 1'b0;
    repeat (2) cyc();
    push("post_rst_nmin", S_NMIN, 9'd1);
    push("post_rst_irqn", S_IRQN, 9'd1);
    cpu_rd("vram_keep", 14'h3ABC, 8'hA5);
    vram_addr = 13'h1001;
    cyc();
    push("vram_keep_vid", S_VDATA, 9'h011);

    repeat (2) cyc();
    if (sb.size() != 0) begin
      $display("FAIL drain: pending %0d want 0", sb.size());
      checks++;
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
